rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two write-back requesters
//  (req0 = ALU/execute, req1 = load/memory) of the MIPS core. Each requester has a
//  one-entry holding slot; the arbiter drains slots into the register file one write per
//  cycle, older first, and flags read-after-write hazards on both read ports.
// PARAMETERS
//  DATA_WIDTH  32  register data width
//  ADDR_WIDTH  5   register index width (32 registers; index 0 hardwired zero)
// PORTS
//  clk         in   1           clock; all state updates on posedge
//  rst         in   1           asynchronous active-low reset
//  req0_valid  in   1           requester 0 has a write
//  req0_ready  out  1           requester 0 slot can accept this cycle
//  req0_addr   in   ADDR_WIDTH  destination register
//  req0_data   in   DATA_WIDTH  write data
//  req1_valid/req1_ready/req1_addr/req1_data  same as req0 for requester 1
//  rf_wen      out  1           register file write enable
//  rf_waddr    out  ADDR_WIDTH  register file write address
//  rf_wdata    out  DATA_WIDTH  register file write data
//  raddr1      in   ADDR_WIDTH  read port 1 address (from decode)
//  raddr2      in   ADDR_WIDTH  read port 2 address
//  hazard1     out  1           raddr1 has a pending, not-yet-committed write
//  hazard2     out  1           raddr2 has a pending, not-yet-committed write
//  idle        out  1           both slots empty
// BEHAVIOUR
//  - Reset (rst=0, async): slots empty, age bit clear, rr pointer -> req0 preferred.
//    Outputs: rf_wen=0, rf_waddr=0, rf_wdata=0, req*_ready=1, idle=1, hazard*=0.
//    Pending slot contents are dropped; no write is issued for them.
//  - Slot k: state {v, addr, data}. reqk_ready = !vk | gntk (same-cycle drain and refill).
//  - Capture on posedge when reqk_valid & reqk_ready. addr==0: accepted, discarded (v stays 0 unless refilled).
//  - Grant (combinational from slot state only): one slot valid -> grant it; both valid ->
//    older slot wins (age bit records which was captured first); equal age (captured same
//    cycle) -> req0 if addresses equal, else rr pointer; pointer flips after a tie grant.
//  - rf_wen = gnt0|gnt1; rf_waddr/rf_wdata muxed from granted slot, zero when no grant.
//    Granted slot clears at the same edge the register file writes.
//  - Latency: capture at edge N -> rf write at edge N+1 at best; max N+2 under contention.
//    Throughput: one write per cycle sustained.
//  - Same-address writes commit in capture order; later write always lands last.
//  - hazardK = (raddrK!=0) & ((v0 & addr0==raddrK) | (v1 & addr1==raddrK)); combinational.
//    Inputs in flight (valid but not yet captured) are not flagged.
//  - idle = !v0 & !v1. No input ever back-pressures the register file.
// STRUCTURE
//  - DATA_WIDTH/ADDR_WIDTH belong in the core's shared defines header, not redefined here.
//  - Sub-module rf_wb_slot: one-entry holding register {v, addr, data} with load/clear,
//    instantiated twice; arbiter, age bit, rr pointer and hazard compare live in the top.
// TESTING
//  - Reset: drive rst=0 mid-run with both slots full -> outputs at reset values, no rf_wen.
//  - Single req0 addr=5 data=0x1234 -> rf_wen=1, waddr=5, wdata=0x1234 one cycle later.
//  - Both valid same cycle, addr 3/4, repeated 4 times -> grants alternate 0,1,1,0...; per rr.
//  - req1 addr=7 data=A, next cycle req0 addr=7 data=B while slot1 pending -> A then B written.
//  - addr=0 on req0 -> ready=1, no rf_wen, hazard1=0 for raddr1=0.
//  - Slot1 holds addr=9, raddr2=9 -> hazard2=1 until commit edge, then 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// Shared types and widths for the register-file write-back arbiter.
package rf_write_arbiter_pkg;

    // Core-wide widths; the arbiter and its slots take them from here.
    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 5;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // One-entry write-back holding slot.
    typedef struct packed {
        logic  v;
        addr_t addr;
        data_t data;
    } slot_t;

    // Relative age of the two slots; only meaningful while both are valid.
    typedef enum logic [1:0] {
        AGE_TIE         = 2'd0,
        AGE_SLOT0_OLDER = 2'd1,
        AGE_SLOT1_OLDER = 2'd2
    } age_e;

    // Round-robin preference used to break ties between same-cycle captures.
    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_e;

    // True when a slot holds a pending write to the given register.
    function automatic logic slot_hits(input slot_t s, input addr_t raddr);
        return s.v && (s.addr == raddr);
    endfunction

    function automatic rr_e rr_flip(input rr_e p);
        return (p == RR_REQ0) ? RR_REQ1 : RR_REQ0;
    endfunction

endpackage

// File: rtl/rf_wb_slot.sv
// One-entry write-back holding register {v, addr, data}.
// A load may coincide with a clear (drain and refill in the same cycle); the
// load wins. Writes to register 0 are accepted but leave the slot empty.
module rf_wb_slot
    import rf_write_arbiter_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  clear_i,
    input  addr_t addr_i,
    input  data_t data_i,
    output slot_t slot_o
);

    slot_t slot_q;
    slot_t slot_d;

    // Next slot contents: refill beats drain, register 0 never becomes valid.
    always_comb begin
        slot_d = slot_q;
        if (load_i) begin
            slot_d.v    = (addr_i != '0);
            slot_d.addr = addr_i;
            slot_d.data = data_i;
        end else if (clear_i) begin
            slot_d.v = 1'b0;
        end
    end

    // Slot register; reset drops any pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file's single write port between the execute (req0) and
// memory (req1) write-back paths. Each path owns a one-entry slot; one slot is
// drained per cycle, oldest first, with a round-robin pointer breaking ties
// between slots captured on the same edge. Pending writes are exposed as
// read-after-write hazards on both decode read ports.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,

    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,

    input  logic [ADDR_WIDTH-1:0] raddr1,
    input  logic [ADDR_WIDTH-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  idle
);

    slot_t slot0;
    slot_t slot1;

    logic  gnt0;
    logic  gnt1;
    logic  tie_grant;

    logic  load0;
    logic  load1;
    logic  fill0;
    logic  fill1;

    age_e  age_q;
    age_e  age_d;
    rr_e   rr_q;
    rr_e   rr_d;

    // A slot accepts when empty or when it is being drained this cycle.
    assign req0_ready = !slot0.v || gnt0;
    assign req1_ready = !slot1.v || gnt1;

    assign load0 = req0_valid && req0_ready;
    assign load1 = req1_valid && req1_ready;

    // Captures that actually occupy a slot (register 0 writes are dropped).
    assign fill0 = load0 && (req0_addr != '0);
    assign fill1 = load1 && (req1_addr != '0);

    rf_wb_slot u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load0),
        .clear_i (gnt0),
        .addr_i  (req0_addr),
        .data_i  (req0_data),
        .slot_o  (slot0)
    );

    rf_wb_slot u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .load_i  (load1),
        .clear_i (gnt1),
        .addr_i  (req1_addr),
        .data_i  (req1_data),
        .slot_o  (slot1)
    );

    // Age and round-robin state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_q <= AGE_TIE;
            rr_q  <= RR_REQ0;
        end else begin
            age_q <= age_d;
            rr_q  <= rr_d;
        end
    end

    // Next age: a lone capture next to a slot that stays pending makes the
    // pending one older; simultaneous captures are a tie. When the other slot
    // is empty or draining, the age value is irrelevant and is reset to a tie.
    always_comb begin
        age_d = age_q;
        if (fill0 && fill1) begin
            age_d = AGE_TIE;
        end else if (fill0) begin
            age_d = (slot1.v && !gnt1) ? AGE_SLOT1_OLDER : AGE_TIE;
        end else if (fill1) begin
            age_d = (slot0.v && !gnt0) ? AGE_SLOT0_OLDER : AGE_TIE;
        end

        rr_d = tie_grant ? rr_flip(rr_q) : rr_q;
    end

    // Grant from slot state only: older slot first; on a tie, equal
    // addresses go to req0 so the pair lands in capture order, otherwise the
    // round-robin pointer decides. The pointer moves after every tie grant.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        tie_grant = 1'b0;
        if (slot0.v && slot1.v) begin
            case (age_q)
                AGE_SLOT0_OLDER: gnt0 = 1'b1;
                AGE_SLOT1_OLDER: gnt1 = 1'b1;
                default: begin
                    tie_grant = 1'b1;
                    if ((slot0.addr == slot1.addr) || (rr_q == RR_REQ0)) begin
                        gnt0 = 1'b1;
                    end else begin
                        gnt1 = 1'b1;
                    end
                end
            endcase
        end else begin
            gnt0 = slot0.v;
            gnt1 = slot1.v;
        end
    end

    // Register-file write port: granted slot's contents, zero when idle.
    always_comb begin
        rf_wen   = gnt0 || gnt1;
        rf_waddr = '0;
        rf_wdata = '0;
        if (gnt0) begin
            rf_waddr = slot0.addr;
            rf_wdata = slot0.data;
        end else if (gnt1) begin
            rf_waddr = slot1.addr;
            rf_wdata = slot1.data;
        end
    end

    // Hazards only consider captured, uncommitted writes; register 0 never hazards.
    always_comb begin
        hazard1 = (raddr1 != '0) && (slot_hits(slot0, raddr1) || slot_hits(slot1, raddr1));
        hazard2 = (raddr2 != '0) && (slot_hits(slot0, raddr2) || slot_hits(slot1, raddr2));
        idle    = !slot0.v && !slot1.v;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vector table, hand-written multi-cycle
// sequences, then randomized traffic against a timestamp-based reference model.
module tb_rf_write_arbiter;
    import rf_write_arbiter_pkg::*;

    logic  clk = 1'b0;
    logic  rst;
    logic  req0_valid, req1_valid, req0_ready, req1_ready;
    addr_t req0_addr, req1_addr, raddr1, raddr2, rf_waddr;
    data_t req0_data, req1_data, rf_wdata;
    logic  rf_wen, hazard1, hazard2, idle;

    always #5 clk = ~clk;

    rf_write_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .raddr1     (raddr1),
        .raddr2     (raddr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .idle       (idle)
    );

    typedef struct packed {
        logic  wen;
        addr_t waddr;
        data_t wdata;
        logic  rdy0;
        logic  rdy1;
        logic  h1;
        logic  h2;
        logic  idle;
    } out_t;

    typedef struct {
        logic  v0;
        addr_t a0;
        data_t d0;
        logic  v1;
        addr_t a1;
        data_t d1;
        addr_t ra1;
        addr_t ra2;
        out_t  exp;
    } vec_t;

    localparam int NVEC = 22;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[NVEC];

    // Reference model state: each slot remembers the cycle it was captured in.
    logic  m_v[2];
    addr_t m_a[2];
    data_t m_d[2];
    int    m_ts[2];
    logic  m_rr;
    int    m_cyc;

    function automatic out_t mk(int wen, int wa, int unsigned wd, int r0, int r1, int h1, int h2, int id);
        out_t o;
        o.wen   = (wen != 0);
        o.waddr = addr_t'(wa);
        o.wdata = data_t'(wd);
        o.rdy0  = (r0 != 0);
        o.rdy1  = (r1 != 0);
        o.h1    = (h1 != 0);
        o.h2    = (h2 != 0);
        o.idle  = (id != 0);
        return o;
    endfunction

    function automatic vec_t row(int v0, int a0, int unsigned d0, int v1, int a1, int unsigned d1,
                                 int ra1, int ra2, out_t exp);
        vec_t r;
        r.v0  = (v0 != 0);
        r.a0  = addr_t'(a0);
        r.d0  = data_t'(d0);
        r.v1  = (v1 != 0);
        r.a1  = addr_t'(a1);
        r.d1  = data_t'(d1);
        r.ra1 = addr_t'(ra1);
        r.ra2 = addr_t'(ra2);
        r.exp = exp;
        return r;
    endfunction

    function automatic string fmt(out_t o);
        return $sformatf("wen=%0b waddr=%0d wdata=%h rdy0=%0b rdy1=%0b hz1=%0b hz2=%0b idle=%0b",
                         o.wen, o.waddr, o.wdata, o.rdy0, o.rdy1, o.h1, o.h2, o.idle);
    endfunction

    task automatic drive(input logic v0, input addr_t a0, input data_t d0,
                         input logic v1, input addr_t a1, input data_t d1,
                         input addr_t ra1, input addr_t ra2);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        raddr1     = ra1;
        raddr2     = ra2;
    endtask

    task automatic drive_none(input addr_t ra1, input addr_t ra2);
        drive(1'b0, '0, '0, 1'b0, '0, '0, ra1, ra2);
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act.wen   = rf_wen;
        act.waddr = rf_waddr;
        act.wdata = rf_wdata;
        act.rdy0  = req0_ready;
        act.rdy1  = req1_ready;
        act.h1    = hazard1;
        act.h2    = hazard2;
        act.idle  = idle;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k]  = 1'b0;
            m_a[k]  = '0;
            m_d[k]  = '0;
            m_ts[k] = 0;
        end
        m_rr  = 1'b0;
        m_cyc = 0;
    endtask

    // Random traffic: inputs driven at the falling edge, outputs compared 1 ns
    // later against the model, then the model is advanced across the rising edge.
    task automatic run_random(input int cycles);
        logic  v[2];
        addr_t a[2];
        data_t d[2];
        addr_t ra1, ra2;
        int    g;
        logic  tie;
        logic  rdy[2];
        out_t  e;
        for (int c = 0; c < cycles; c++) begin
            for (int k = 0; k < 2; k++) begin
                v[k] = ($urandom_range(0, 9) < 7);
                a[k] = addr_t'($urandom_range(0, 7));
                d[k] = data_t'($urandom);
            end
            ra1 = addr_t'($urandom_range(0, 7));
            ra2 = addr_t'($urandom_range(0, 7));
            drive(v[0], a[0], d[0], v[1], a[1], d[1], ra1, ra2);
            #1;

            g   = -1;
            tie = 1'b0;
            if (m_v[0] && m_v[1]) begin
                if (m_ts[0] < m_ts[1]) begin
                    g = 0;
                end else if (m_ts[1] < m_ts[0]) begin
                    g = 1;
                end else begin
                    tie = 1'b1;
                    g   = ((m_a[0] == m_a[1]) || !m_rr) ? 0 : 1;
                end
            end else if (m_v[0]) begin
                g = 0;
            end else if (m_v[1]) begin
                g = 1;
            end

            e = '0;
            if (g >= 0) begin
                e.wen   = 1'b1;
                e.waddr = m_a[g];
                e.wdata = m_d[g];
            end
            rdy[0] = !m_v[0] || (g == 0);
            rdy[1] = !m_v[1] || (g == 1);
            e.rdy0 = rdy[0];
            e.rdy1 = rdy[1];
            e.h1   = (ra1 != 0) && ((m_v[0] && m_a[0] == ra1) || (m_v[1] && m_a[1] == ra1));
            e.h2   = (ra2 != 0) && ((m_v[0] && m_a[0] == ra2) || (m_v[1] && m_a[1] == ra2));
            e.idle = !m_v[0] && !m_v[1];
            check($sformatf("random_c%0d", c), e);

            if (tie) m_rr = !m_rr;
            if (g >= 0) m_v[g] = 1'b0;
            for (int k = 0; k < 2; k++) begin
                if (v[k] && rdy[k] && a[k] != 0) begin
                    m_v[k]  = 1'b1;
                    m_a[k]  = a[k];
                    m_d[k]  = d[k];
                    m_ts[k] = m_cyc;
                end
            end
            m_cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        //           v0 a0 d0         v1 a1 d1        ra1 ra2   wen wa wd  r0 r1 h1 h2 idle
        tbl[0]  = row(1, 5, 'h1234,   0, 0, 0,        5, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[1]  = row(0, 0, 0,        0, 0, 0,        5, 5, mk(1, 5, 'h1234,  1, 1, 1, 1, 0));
        tbl[2]  = row(1, 3, 'h3,      1, 4, 'h4,      3, 4, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[3]  = row(0, 0, 0,        0, 0, 0,        3, 4, mk(1, 3, 'h3,     1, 0, 1, 1, 0));
        tbl[4]  = row(0, 0, 0,        0, 0, 0,        3, 4, mk(1, 4, 'h4,     1, 1, 0, 1, 0));
        tbl[5]  = row(1, 3, 'h33,     1, 4, 'h44,     0, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[6]  = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 4, 'h44,    0, 1, 0, 0, 0));
        tbl[7]  = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 3, 'h33,    1, 1, 0, 0, 0));
        tbl[8]  = row(1, 3, 'h300,    1, 4, 'h400,    0, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[9]  = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 3, 'h300,   1, 0, 0, 0, 0));
        tbl[10] = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 4, 'h400,   1, 1, 0, 0, 0));
        tbl[11] = row(1, 3, 'h3000,   1, 4, 'h4000,   0, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[12] = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 4, 'h4000,  0, 1, 0, 0, 0));
        tbl[13] = row(0, 0, 0,        0, 0, 0,        0, 0, mk(1, 3, 'h3000,  1, 1, 0, 0, 0));
        tbl[14] = row(0, 0, 0,        1, 7, 'hA,      7, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[15] = row(1, 7, 'hB,      0, 0, 0,        7, 0, mk(1, 7, 'hA,     1, 1, 1, 0, 0));
        tbl[16] = row(0, 0, 0,        0, 0, 0,        7, 0, mk(1, 7, 'hB,     1, 1, 1, 0, 0));
        tbl[17] = row(1, 0, 'hDEAD,   0, 0, 0,        0, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[18] = row(0, 0, 0,        0, 0, 0,        0, 0, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[19] = row(0, 0, 0,        1, 9, 'h99,     0, 9, mk(0, 0, 0,       1, 1, 0, 0, 1));
        tbl[20] = row(0, 0, 0,        0, 0, 0,        0, 9, mk(1, 9, 'h99,    1, 1, 0, 1, 0));
        tbl[21] = row(0, 0, 0,        0, 0, 0,        0, 9, mk(0, 0, 0,       1, 1, 0, 0, 1));

        rst = 1'b0;
        drive_none('0, '0);
        repeat (3) @(negedge clk);
        #1 check("reset_state", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table (rr pointer starts at req0).
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].ra1, tbl[i].ra2);
            #1;
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(negedge clk);
        end

        // Move the rr pointer to req1, fill both slots, then reset mid-cycle.
        drive(1'b1, 5'd3, 32'h5, 1'b1, 5'd4, 32'h6, '0, '0);
        @(negedge clk);
        drive_none('0, '0);
        #1 check("pre_reset_tie", mk(1, 3, 'h5, 1, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("pre_reset_drain", mk(1, 4, 'h6, 1, 1, 0, 0, 0));
        @(negedge clk);
        drive(1'b1, 5'd11, 32'h11, 1'b1, 5'd12, 32'h12, 5'd11, 5'd12);
        @(negedge clk);
        drive_none(5'd11, 5'd12);
        #1 check("both_full_rr_req1", mk(1, 12, 'h12, 0, 1, 1, 1, 0));
        #2 rst = 1'b0;
        #1 check("reset_async", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(posedge clk);
        #1 check("reset_no_write", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(negedge clk);
        rst = 1'b1;
        #1 check("reset_slots_dropped", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(negedge clk);
        drive(1'b1, 5'd3, 32'h7, 1'b1, 5'd4, 32'h8, '0, '0);
        @(negedge clk);
        drive_none('0, '0);
        #1 check("rr_after_reset", mk(1, 3, 'h7, 1, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("rr_after_reset_drain", mk(1, 4, 'h8, 1, 1, 0, 0, 0));
        @(negedge clk);

        // Streaming after a tie: age must override the rr pointer (rr = req1 here).
        drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 5'd20, 5'd23);
        #1 check("age_capture", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(negedge clk);
        drive(1'b0, '0, '0, 1'b1, 5'd23, 32'h23, 5'd20, 5'd23);
        #1 check("age_tie_rr", mk(1, 21, 'h21, 0, 1, 1, 0, 0));
        @(negedge clk);
        drive(1'b1, 5'd24, 32'h24, 1'b0, '0, '0, 5'd20, 5'd23);
        #1 check("age_slot0_older", mk(1, 20, 'h20, 1, 0, 1, 1, 0));
        @(negedge clk);
        drive_none(5'd20, 5'd23);
        #1 check("age_over_rr", mk(1, 23, 'h23, 0, 1, 0, 1, 0));
        @(negedge clk);
        #1 check("age_drain", mk(1, 24, 'h24, 1, 1, 0, 0, 0));
        @(negedge clk);

        // Same-address tie with rr pointing at req1: req0 still commits first.
        drive(1'b1, 5'd3, 32'h9, 1'b1, 5'd4, 32'hA, '0, '0);
        @(negedge clk);
        drive_none('0, '0);
        #1 check("waw_setup", mk(1, 3, 'h9, 1, 0, 0, 0, 0));
        @(negedge clk);
        #1 check("waw_setup_drain", mk(1, 4, 'hA, 1, 1, 0, 0, 0));
        @(negedge clk);
        drive(1'b1, 5'd30, 32'h1, 1'b1, 5'd30, 32'h2, 5'd30, '0);
        @(negedge clk);
        drive_none(5'd30, '0);
        #1 check("waw_first_req0", mk(1, 30, 'h1, 1, 0, 1, 0, 0));
        @(negedge clk);
        #1 check("waw_last_req1", mk(1, 30, 'h2, 1, 1, 1, 0, 0));
        @(negedge clk);
        #1 check("waw_done", mk(0, 0, 0, 1, 1, 0, 0, 1));
        @(negedge clk);

        // Randomized traffic from a fresh reset.
        rst = 1'b0;
        drive_none('0, '0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        run_random(2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
